// File: rtl/video_pkg.sv
// Shared video types: RGB565/RGB888 pixels, scan flag bundle and raster total helper.
package video_pkg;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Per-pixel raster flags carried alongside the read latency.
  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
    logic first;
  } scan_flags_t;

  // MSB replication so full-scale 565 maps to full-scale 888.
  function automatic rgb888_t rgb565_to_888(input rgb565_t c);
    rgb888_t o;
    o.r = {c.r, c.r[4:2]};
    o.g = {c.g, c.g[5:4]};
    o.b = {c.b, c.b[4:2]};
    return o;
  endfunction

  function automatic int unsigned scan_total(input int unsigned active, input int unsigned front,
                                             input int unsigned sync, input int unsigned back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/scanout_timing.sv
// Raster h/v counters with registered active/sync/first-pixel/frame-end decode.
// Decode is computed from the next counter values so each flag lines up with the counter it describes.
module scanout_timing
  import video_pkg::*;
#(
  parameter int DISPLAY_WIDTH  = 100,
  parameter int DISPLAY_HEIGHT = 100,
  parameter int H_FRONT = 8,
  parameter int H_SYNC  = 16,
  parameter int H_BACK  = 8,
  parameter int V_FRONT = 2,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 4
) (
  input  logic clk,
  input  logic rst,
  output logic active,
  output logic hsync_on,
  output logic vsync_on,
  output logic first_pixel,
  output logic frame_end
);

  localparam int H_TOTAL = scan_total(DISPLAY_WIDTH, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = scan_total(DISPLAY_HEIGHT, V_FRONT, V_SYNC, V_BACK);
  localparam int H_BITS  = $clog2(H_TOTAL + 1);
  localparam int V_BITS  = $clog2(V_TOTAL + 1);

  localparam logic [H_BITS-1:0] H_LAST   = H_BITS'(H_TOTAL - 1);
  localparam logic [V_BITS-1:0] V_LAST   = V_BITS'(V_TOTAL - 1);
  localparam logic [H_BITS-1:0] H_ACT    = H_BITS'(DISPLAY_WIDTH);
  localparam logic [V_BITS-1:0] V_ACT    = V_BITS'(DISPLAY_HEIGHT);
  localparam logic [H_BITS-1:0] HS_START = H_BITS'(DISPLAY_WIDTH + H_FRONT);
  localparam logic [H_BITS-1:0] HS_END   = H_BITS'(DISPLAY_WIDTH + H_FRONT + H_SYNC);
  localparam logic [V_BITS-1:0] VS_START = V_BITS'(DISPLAY_HEIGHT + V_FRONT);
  localparam logic [V_BITS-1:0] VS_END   = V_BITS'(DISPLAY_HEIGHT + V_FRONT + V_SYNC);

  logic [H_BITS-1:0] h, h_nxt;
  logic [V_BITS-1:0] v, v_nxt;

  always_comb begin
    h_nxt = h + 1'b1;
    v_nxt = v;
    if (h == H_LAST) begin
      h_nxt = '0;
      v_nxt = (v == V_LAST) ? '0 : v + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h           <= '0;
      v           <= '0;
      active      <= 1'b1;
      hsync_on    <= 1'b0;
      vsync_on    <= 1'b0;
      first_pixel <= 1'b1;
      frame_end   <= 1'b0;
    end else begin
      h           <= h_nxt;
      v           <= v_nxt;
      active      <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
      hsync_on    <= (h_nxt >= HS_START) && (h_nxt < HS_END);
      vsync_on    <= (v_nxt >= VS_START) && (v_nxt < VS_END);
      first_pixel <= (h_nxt == '0) && (v_nxt == '0);
      frame_end   <= (h_nxt == H_LAST) && (v_nxt == V_LAST);
    end
  end

endmodule

// File: rtl/framebuffer_scanout.sv
// Framebuffer display reader: running read address, flag delay matching the memory latency,
// RGB565->RGB888 expansion and aligned output registers (outputs lag counters by READ_LATENCY+1).
module framebuffer_scanout
  import video_pkg::*;
#(
  parameter int DISPLAY_WIDTH         = 100,
  parameter int DISPLAY_HEIGHT        = 100,
  parameter int H_FRONT               = 8,
  parameter int H_SYNC                = 16,
  parameter int H_BACK                = 8,
  parameter int V_FRONT               = 2,
  parameter int V_SYNC                = 2,
  parameter int V_BACK                = 4,
  parameter int SYNC_ACTIVE_LOW       = 1,
  parameter int READ_LATENCY          = 1,
  parameter int FRAMEBUFFER_DATA_BITS = 16,
  parameter int FRAMEBUFFER_SIZE      = DISPLAY_WIDTH * DISPLAY_HEIGHT,
  parameter int FRAMEBUFFER_ADDR_BITS = $clog2(FRAMEBUFFER_SIZE)
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic [FRAMEBUFFER_ADDR_BITS-1:0] framebuffer_rd_addr,
  input  logic [FRAMEBUFFER_DATA_BITS-1:0] framebuffer_rd_data,
  output logic [7:0]                       pixel_r,
  output logic [7:0]                       pixel_g,
  output logic [7:0]                       pixel_b,
  output logic                             data_enable,
  output logic                             hsync,
  output logic                             vsync,
  output logic                             frame_start
);

  localparam logic [FRAMEBUFFER_ADDR_BITS-1:0] ADDR_LAST =
    FRAMEBUFFER_ADDR_BITS'(FRAMEBUFFER_SIZE - 1);
  localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

  logic t_active, t_hsync, t_vsync, t_first, t_frame_end;

  scanout_timing #(
    .DISPLAY_WIDTH (DISPLAY_WIDTH),
    .DISPLAY_HEIGHT(DISPLAY_HEIGHT),
    .H_FRONT       (H_FRONT),
    .H_SYNC        (H_SYNC),
    .H_BACK        (H_BACK),
    .V_FRONT       (V_FRONT),
    .V_SYNC        (V_SYNC),
    .V_BACK        (V_BACK)
  ) u_timing (
    .clk        (clk),
    .rst        (rst),
    .active     (t_active),
    .hsync_on   (t_hsync),
    .vsync_on   (t_vsync),
    .first_pixel(t_first),
    .frame_end  (t_frame_end)
  );

  // Address follows the counters; it rewinds on the last raster cycle so (0,0) always reads 0.
  always_ff @(posedge clk) begin
    if (rst || t_frame_end) begin
      framebuffer_rd_addr <= '0;
    end else if (t_active && (framebuffer_rd_addr != ADDR_LAST)) begin
      framebuffer_rd_addr <= framebuffer_rd_addr + 1'b1;
    end
  end

  scan_flags_t pipe [READ_LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{de: t_active, hsync: t_hsync, vsync: t_vsync, first: t_first};
      for (int i = 1; i < READ_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  scan_flags_t aligned;
  rgb888_t     px;

  assign aligned = pipe[READ_LATENCY-1];
  assign px      = rgb565_to_888(rgb565_t'(framebuffer_rd_data[15:0]));

  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_r     <= '0;
      pixel_g     <= '0;
      pixel_b     <= '0;
      data_enable <= 1'b0;
      frame_start <= 1'b0;
      hsync       <= SYNC_IDLE;
      vsync       <= SYNC_IDLE;
    end else begin
      pixel_r     <= aligned.de ? px.r : 8'h00;
      pixel_g     <= aligned.de ? px.g : 8'h00;
      pixel_b     <= aligned.de ? px.b : 8'h00;
      data_enable <= aligned.de;
      frame_start <= aligned.first;
      hsync       <= aligned.hsync ^ SYNC_IDLE;
      vsync       <= aligned.vsync ^ SYNC_IDLE;
    end
  end

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Directed bench: 4x2 active raster, H_TOTAL=8, V_TOTAL=5, one-clock memory model.
module tb_framebuffer_scanout;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data = '0;
  logic [7:0]  pr, pg, pb;
  logic        de, hs, vs, fs;

  logic [15:0] mem    [8];
  logic [23:0] exp_px [8];

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  framebuffer_scanout #(
    .DISPLAY_WIDTH(4), .DISPLAY_HEIGHT(2),
    .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_ACTIVE_LOW(1), .READ_LATENCY(1)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .framebuffer_rd_addr(rd_addr),
    .framebuffer_rd_data(rd_data),
    .pixel_r            (pr),
    .pixel_g            (pg),
    .pixel_b            (pb),
    .data_enable        (de),
    .hsync              (hs),
    .vsync              (vs),
    .frame_start        (fs)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= mem[rd_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_de"},  {31'd0, de}, 32'd0);
    chk({tag, "_fs"},  {31'd0, fs}, 32'd0);
    chk({tag, "_hs"},  {31'd0, hs}, 32'd1);
    chk({tag, "_vs"},  {31'd0, vs}, 32'd1);
    chk({tag, "_rgb"}, {8'd0, pr, pg, pb}, 32'd0);
  endtask

  initial begin
    int idx, h, v, ah, av, ea;
    logic e_de;

    mem    = '{16'hF800, 16'h07E0, 16'h001F, 16'h8410,
               16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    exp_px = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h848284,
               24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    chk("reset_addr", {29'd0, rd_addr}, 32'd0);
    rst = 1'b0;

    // Outputs at negedge n show counter index n-1; the address shows index n+1.
    for (int n = 0; n <= 51; n++) begin
      @(posedge clk);
      @(negedge clk);
      idx = n - 1;
      if (idx < 0) begin
        chk_idle("startup");
      end else begin
        h    = idx % 8;
        v    = (idx / 8) % 5;
        e_de = (h < 4) && (v < 2);
        chk("de", {31'd0, de}, {31'd0, e_de});
        chk("frame_start", {31'd0, fs}, {31'd0, (idx % 40) == 0});
        chk("hsync", {31'd0, hs}, {31'd0, !(h >= 5 && h < 7)});
        chk("vsync", {31'd0, vs}, {31'd0, (v != 3)});
        chk("rgb", {8'd0, pr, pg, pb}, e_de ? {8'd0, exp_px[v*4+h]} : 32'd0);
      end
      ah = (n + 1) % 8;
      av = ((n + 1) / 8) % 5;
      if (av >= 2)     ea = 7;
      else if (ah < 4) ea = av * 4 + ah;
      else             ea = av * 4 + 4;
      if (ea > 7) ea = 7;
      chk("rd_addr", {29'd0, rd_addr}, ea);
    end

    // Outputs now show pixel (2,1); reset mid-frame must flush everything.
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_idle("midreset");
    chk("midreset_addr", {29'd0, rd_addr}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_idle("restart");
    chk("restart_addr", {29'd0, rd_addr}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("restart_de", {31'd0, de}, 32'd1);
    chk("restart_fs", {31'd0, fs}, 32'd1);
    chk("restart_hs", {31'd0, hs}, 32'd1);
    chk("restart_vs", {31'd0, vs}, 32'd1);
    chk("restart_rgb", {8'd0, pr, pg, pb}, 32'h00FF0000);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
